wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width of all three buses.
REQ-002 SHALL have parameter IDLE_HANDOFF, default 1; 1 means direct grant handoff without passing through IDLE.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have port m0, wishbone.SLAVE, XLEN, instruction-fetch requester.
REQ-006 SHALL have port m1, wishbone.SLAVE, XLEN, load/store requester.
REQ-007 SHALL have port s, wishbone.MASTER, XLEN, shared downstream memory bus.
REQ-008 SHALL have port grant, output, 2, registered one-hot current owner (bit0=m0, bit1=m1, 00=none).

Function
REQ-009 SHALL implement FSM states IDLE, OWN0, OWN1, encoded in the package enum.
REQ-010 A requester SHALL be "requesting" when its CYC=1 and STB=1.
REQ-011 IDLE: with exactly one requester, SHALL enter OWNx at next edge; with none, SHALL stay IDLE.
REQ-012 IDLE with both requesting SHALL resolve per REQ-022/REQ-023.
REQ-013 OWNx SHALL hold while mx.CYC=1, regardless of STB or ACK, keeping multi-beat cycles atomic.
REQ-014 OWNx with mx.CYC=0: if IDLE_HANDOFF=1 and the other requester is requesting, SHALL go directly to OWNy; otherwise SHALL go to IDLE.
REQ-015 In OWNx, s.ADR/SEL/WE/STB/CYC/DAT_W SHALL equal mx's combinationally (zero added latency); in IDLE, all s outputs SHALL be 0.
REQ-016 mx.ACK SHALL be s.ACK gated by ownership; non-owner ACK SHALL be 0.
REQ-017 mx.DAT_R SHALL be s.DAT_R for both requesters (shared, qualified by ACK).
REQ-018 Grant latency: request first seen at edge N -> s.CYC=1 during cycle after edge N+1; no earlier.
REQ-019 A non-owner SHALL stall (no ACK) indefinitely until granted; no request is dropped.
REQ-020 s.ACK arriving in IDLE SHALL be ignored (forwarded to nobody).
REQ-021 grant SHALL equal 2'b01 in OWN0, 2'b10 in OWN1, 2'b00 in IDLE.

Configuration
REQ-022 With macro WB_ARB_ROUND_ROBIN_EN defined, a register last (reset to m1) SHALL record the last owner; on contention the requester that is not last SHALL win; last SHALL update on entry to OWNx.
REQ-023 Without WB_ARB_ROUND_ROBIN_EN, contention SHALL be fixed priority: m1 (load/store) wins over m0; no last register SHALL exist.

Reset
REQ-024 rst_n=0 SHALL asynchronously force IDLE, grant=00, last=m1, and all s outputs and mx.ACK to 0, including mid-transaction.
REQ-025 After rst_n deasserts, the first grant SHALL occur no earlier than the second rising edge.

Structure
REQ-026 Package wb_arb_pkg SHALL hold the state enum (IDLE, OWN0, OWN1) and owner-index localparams M0=0, M1=1.
REQ-027 The wishbone interface SHALL be reused unchanged; no new interface SHALL be defined.
REQ-028 Priority resolution SHALL be sub-module wb_arb_pick (inputs req[1:0], last; output winner); the mux/FSM stays in wb_arbiter.
REQ-029 Target size SHALL be 120-250 RTL lines total.

Verification
REQ-030 Single m0 read ADR=0x100, slave ACK 2 cycles after STB -> s.ADR=0x100 one cycle after request, m0.ACK=1 once, m1.ACK=0 throughout.
REQ-031 Both request same cycle, macro off -> m1 granted first (grant=10); m0 granted on m1 CYC drop, same edge (grant 10->01) with IDLE_HANDOFF=1.
REQ-032 Macro on, both request continuously for 4 single-beat cycles -> grant sequence 01,10,01,10.
REQ-033 m1 holds CYC=1 for 3 beats with STB low between beats while m0 requests -> m0 never granted until m1 CYC=0; m0 sees no ACK.
REQ-034 rst_n pulsed low mid m0 write (WE=1, SEL=4'hF) -> s.CYC/STB/WE=0 and grant=00 immediately, IDLE after release.
REQ-035 Spurious s.ACK=1 in IDLE -> m0.ACK=m1.ACK=0, state stays IDLE.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared types for the two-requester Wishbone arbiter.
// Optional build macro WB_ARB_ROUND_ROBIN_EN selects round-robin contention
// resolution; without it, the load/store port (m1) has fixed priority.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  // Owner indices as carried on the winner/last signals.
  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  // One-hot owner vector for a given bus state (00 when nobody owns it).
  function automatic logic [1:0] grant_of(input state_e st);
    logic [1:0] g;
    g = 2'b00;
    case (st)
      OWN0:    g = 2'b01;
      OWN1:    g = 2'b10;
      default: g = 2'b00;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/wishbone.sv
// Standard Wishbone bus interface shared across the codebase.
// MASTER drives the cycle; SLAVE answers with ACK and read data.
interface wishbone #(
  parameter int XLEN = 32
);

  logic [XLEN-1:0]   ADR;
  logic [XLEN-1:0]   DAT_W;
  logic [XLEN-1:0]   DAT_R;
  logic [XLEN/8-1:0] SEL;
  logic              WE;
  logic              STB;
  logic              CYC;
  logic              ACK;

  modport MASTER (
    output ADR, DAT_W, SEL, WE, STB, CYC,
    input  DAT_R, ACK
  );

  modport SLAVE (
    input  ADR, DAT_W, SEL, WE, STB, CYC,
    output DAT_R, ACK
  );

endinterface

// File: rtl/wb_arb_pick.sv
// Contention resolver for the Wishbone arbiter.
// With WB_ARB_ROUND_ROBIN_EN defined, a tie goes to the requester that did
// not own the bus last; otherwise m1 (load/store) always wins a tie.
// With a single requester the winner is simply that requester.
module wb_arb_pick
  import wb_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       winner
);

`ifdef WB_ARB_ROUND_ROBIN_EN
  // Alternate on a tie, otherwise pick whoever is asking.
  always_comb begin
    winner = req[1] ? M1 : M0;
    if (req == 2'b11) begin
      winner = (last == M1) ? M0 : M1;
    end
  end
`else
  // Fixed priority: m1 beats m0; the last-owner input carries no state here.
  logic unused_last;
  assign unused_last = last;

  always_comb begin
    winner = req[1] ? M1 : M0;
  end
`endif

endmodule

// File: rtl/wb_arbiter.sv
// Two-requester Wishbone arbiter: m0 (instruction fetch) and m1 (load/store)
// share one downstream bus s. Ownership lasts for the whole CYC of the
// owner so multi-beat cycles stay atomic. Optional build macro
// WB_ARB_ROUND_ROBIN_EN enables round-robin tie-breaking (see wb_arb_pick).
module wb_arbiter
  import wb_arb_pkg::*;
#(
  parameter int          XLEN         = 32,
  parameter int unsigned IDLE_HANDOFF = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  wishbone.SLAVE      m0,
  wishbone.SLAVE      m1,
  wishbone.MASTER     s,
  output logic [1:0]  grant
);

  logic       req0;
  logic       req1;
  logic       winner;
  logic       pick_last;
  state_e     state_q, state_d;
  logic [1:0] grant_q, grant_d;
  // Set on the first edge after reset release; no grant is issued before it
  // so the earliest possible grant lands on the second edge.
  logic       armed_q;

  assign req0 = m0.CYC & m0.STB;
  assign req1 = m1.CYC & m1.STB;

  wb_arb_pick u_pick (
    .req    ({req1, req0}),
    .last   (pick_last),
    .winner (winner)
  );

  // Next-state logic: grab from IDLE, hold for the owner's whole CYC.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can leave it unassigned and infer a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (armed_q && (req0 || req1)) begin
          state_d = (winner == M1) ? OWN1 : OWN0;
        end
      end
      OWN0: begin
        if (!m0.CYC) begin
          state_d = ((IDLE_HANDOFF != 0) && req1) ? OWN1 : IDLE;
        end
      end
      OWN1: begin
        if (!m1.CYC) begin
          state_d = ((IDLE_HANDOFF != 0) && req0) ? OWN0 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    grant_d = grant_of(state_d);
  end

  // State, grant and arming registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      armed_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep all flops updating from pre-edge values, avoiding order-dependent races.
      state_q <= state_d;
      grant_q <= grant_d;
      armed_q <= 1'b1;
    end
  end

  assign grant = grant_q;

`ifdef WB_ARB_ROUND_ROBIN_EN
  logic last_q, last_d;

  // Remember who most recently took the bus, updated on entry to OWNx.
  always_comb begin
    last_d = last_q;
    if (state_d == OWN0 && state_q != OWN0) last_d = M0;
    if (state_d == OWN1 && state_q != OWN1) last_d = M1;
  end

  // Last-owner register; m1 after reset so m0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= M1;
    else        last_q <= last_d;
  end

  assign pick_last = last_q;
`else
  assign pick_last = M1;
`endif

  // Bus mux: the owner drives s with no added latency; IDLE drives zeros.
  // ACK goes only to the owner, so an ACK seen in IDLE reaches nobody.
  always_comb begin
    s.ADR   = {XLEN{1'b0}};
    s.DAT_W = {XLEN{1'b0}};
    s.SEL   = '0;
    s.WE    = 1'b0;
    s.STB   = 1'b0;
    s.CYC   = 1'b0;
    m0.ACK  = 1'b0;
    m1.ACK  = 1'b0;
    m0.DAT_R = s.DAT_R;
    m1.DAT_R = s.DAT_R;
    case (state_q)
      OWN0: begin
        s.ADR   = m0.ADR;
        s.DAT_W = m0.DAT_W;
        s.SEL   = m0.SEL;
        s.WE    = m0.WE;
        s.STB   = m0.STB;
        s.CYC   = m0.CYC;
        m0.ACK  = s.ACK;
      end
      OWN1: begin
        s.ADR   = m1.ADR;
        s.DAT_W = m1.DAT_W;
        s.SEL   = m1.SEL;
        s.WE    = m1.WE;
        s.STB   = m1.STB;
        s.CYC   = m1.CYC;
        m1.ACK  = s.ACK;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter. Inputs change on the falling
// edge; outputs are sampled 1 ns later, well away from the rising edge.
// Build with or without WB_ARB_ROUND_ROBIN_EN; expectations follow the macro.
module tb_wb_arbiter;

  logic       clk;
  logic       rst_n;
  logic [1:0] grant;
  int         errors;
  int         checks;
  logic [1:0] exp_seq [4];

  wishbone #(.XLEN(32)) m0_bus ();
  wishbone #(.XLEN(32)) m1_bus ();
  wishbone #(.XLEN(32)) s_bus ();

  wb_arbiter #(
    .XLEN         (32),
    .IDLE_HANDOFF (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .m0    (m0_bus),
    .m1    (m1_bus),
    .s     (s_bus),
    .grant (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_idle();
    m0_bus.CYC = 1'b0; m0_bus.STB = 1'b0; m0_bus.WE = 1'b0;
    m0_bus.SEL = 4'h0; m0_bus.ADR = '0;   m0_bus.DAT_W = '0;
    m1_bus.CYC = 1'b0; m1_bus.STB = 1'b0; m1_bus.WE = 1'b0;
    m1_bus.SEL = 4'h0; m1_bus.ADR = '0;   m1_bus.DAT_W = '0;
  endtask

  task automatic m0_req(input logic [31:0] adr, input logic we, input logic [31:0] dat);
    m0_bus.CYC = 1'b1; m0_bus.STB = 1'b1; m0_bus.WE = we;
    m0_bus.SEL = 4'hF; m0_bus.ADR = adr;  m0_bus.DAT_W = dat;
  endtask

  task automatic m1_req(input logic [31:0] adr, input logic we, input logic [31:0] dat);
    m1_bus.CYC = 1'b1; m1_bus.STB = 1'b1; m1_bus.WE = we;
    m1_bus.SEL = 4'hF; m1_bus.ADR = adr;  m1_bus.DAT_W = dat;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    m_idle();
    s_bus.ACK = 1'b0;
    s_bus.DAT_R = 32'h0;

    // Reset state
    #2;
    check("rst_grant", grant, 2'b00);
    check("rst_s_cyc", s_bus.CYC, 1'b0);
    check("rst_s_stb", s_bus.STB, 1'b0);
    repeat (2) @(negedge clk);

    // Release reset with m0 already requesting: first edge must not grant
    rst_n = 1'b1;
    m0_req(32'h100, 1'b0, 32'h0);
    @(negedge clk); #1;
    check("arm_edge1_grant", grant, 2'b00);
    check("arm_edge1_s_cyc", s_bus.CYC, 1'b0);
    @(negedge clk); #1;
    check("arm_edge2_grant", grant, 2'b01);
    check("arm_edge2_s_adr", s_bus.ADR, 32'h100);
    m_idle();
    @(negedge clk); #1;
    check("arm_release_grant", grant, 2'b00);

    // Single m0 read, slave ACKs two cycles after STB
    m0_req(32'h100, 1'b0, 32'h0);
    @(negedge clk); #1;
    check("rd_grant", grant, 2'b01);
    check("rd_s_adr", s_bus.ADR, 32'h100);
    check("rd_s_stb", s_bus.STB, 1'b1);
    check("rd_m0_ack_wait0", m0_bus.ACK, 1'b0);
    check("rd_m1_ack_wait0", m1_bus.ACK, 1'b0);
    @(negedge clk); #1;
    check("rd_m0_ack_wait1", m0_bus.ACK, 1'b0);
    @(negedge clk);
    s_bus.ACK = 1'b1; s_bus.DAT_R = 32'hDEAD_BEEF; #1;
    check("rd_m0_ack", m0_bus.ACK, 1'b1);
    check("rd_m0_dat", m0_bus.DAT_R, 32'hDEAD_BEEF);
    check("rd_m1_ack", m1_bus.ACK, 1'b0);
    @(negedge clk);
    s_bus.ACK = 1'b0; m_idle(); #1;
    check("rd_m0_ack_done", m0_bus.ACK, 1'b0);
    @(negedge clk); #1;
    check("rd_idle_grant", grant, 2'b00);

    // Simultaneous requests: m1 wins, then direct handoff to m0
    m0_req(32'h200, 1'b0, 32'h0);
    m1_req(32'h300, 1'b1, 32'hCAFE_F00D);
    @(negedge clk); #1;
    check("ct_grant_m1", grant, 2'b10);
    check("ct_s_adr_m1", s_bus.ADR, 32'h300);
    check("ct_s_we_m1", s_bus.WE, 1'b1);
    check("ct_s_datw_m1", s_bus.DAT_W, 32'hCAFE_F00D);
    s_bus.ACK = 1'b1; #1;
    check("ct_m1_ack", m1_bus.ACK, 1'b1);
    check("ct_m0_ack_stall", m0_bus.ACK, 1'b0);
    @(negedge clk);
    s_bus.ACK = 1'b0;
    m1_bus.CYC = 1'b0; m1_bus.STB = 1'b0; m1_bus.WE = 1'b0; #1;
    check("ct_grant_hold", grant, 2'b10);
    @(negedge clk); #1;
    check("ct_grant_m0", grant, 2'b01);
    check("ct_s_adr_m0", s_bus.ADR, 32'h200);
    check("ct_s_we_m0", s_bus.WE, 1'b0);
    s_bus.ACK = 1'b1; #1;
    check("ct_m0_ack", m0_bus.ACK, 1'b1);
    check("ct_m1_ack_off", m1_bus.ACK, 1'b0);
    @(negedge clk);
    s_bus.ACK = 1'b0; m_idle();
    @(negedge clk); #1;
    check("ct_idle_grant", grant, 2'b00);

    // m1 holds CYC for three beats with STB gaps; m0 waits throughout
    m1_req(32'h500, 1'b0, 32'h0);
    @(negedge clk); #1;
    check("mb_grant_m1", grant, 2'b10);
    m0_req(32'h600, 1'b0, 32'h0);
    for (int beat = 0; beat < 3; beat++) begin
      m1_bus.STB = 1'b1; s_bus.ACK = 1'b1; #1;
      check("mb_m1_ack", m1_bus.ACK, 1'b1);
      check("mb_m0_ack_beat", m0_bus.ACK, 1'b0);
      check("mb_grant_beat", grant, 2'b10);
      @(negedge clk);
      m1_bus.STB = 1'b0; s_bus.ACK = 1'b0; #1;
      check("mb_s_stb_gap", s_bus.STB, 1'b0);
      check("mb_s_cyc_gap", s_bus.CYC, 1'b1);
      check("mb_m0_ack_gap", m0_bus.ACK, 1'b0);
      @(negedge clk); #1;
      check("mb_grant_gap", grant, 2'b10);
    end
    m1_bus.CYC = 1'b0;
    @(negedge clk); #1;
    check("mb_grant_m0", grant, 2'b01);
    check("mb_s_adr_m0", s_bus.ADR, 32'h600);
    s_bus.ACK = 1'b1; #1;
    check("mb_m0_ack", m0_bus.ACK, 1'b1);
    @(negedge clk);
    s_bus.ACK = 1'b0; m_idle();
    @(negedge clk); #1;
    check("mb_idle_grant", grant, 2'b00);

    // Reset asserted in the middle of an m0 write
    m0_req(32'h400, 1'b1, 32'h1234_5678);
    @(negedge clk); #1;
    check("wr_grant", grant, 2'b01);
    check("wr_s_we", s_bus.WE, 1'b1);
    check("wr_s_sel", s_bus.SEL, 4'hF);
    #1;
    s_bus.ACK = 1'b1;
    rst_n = 1'b0; #1;
    check("wr_rst_s_cyc", s_bus.CYC, 1'b0);
    check("wr_rst_s_stb", s_bus.STB, 1'b0);
    check("wr_rst_s_we", s_bus.WE, 1'b0);
    check("wr_rst_grant", grant, 2'b00);
    check("wr_rst_m0_ack", m0_bus.ACK, 1'b0);
    s_bus.ACK = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    check("wr_post_rst_grant", grant, 2'b00);
    m_idle();
    @(negedge clk); #1;
    check("wr_post_rst_idle", grant, 2'b00);

    // Spurious slave ACK while idle
    s_bus.ACK = 1'b1; #1;
    check("sp_m0_ack", m0_bus.ACK, 1'b0);
    check("sp_m1_ack", m1_bus.ACK, 1'b0);
    @(negedge clk); #1;
    check("sp_grant", grant, 2'b00);
    check("sp_s_cyc", s_bus.CYC, 1'b0);
    s_bus.ACK = 1'b0;

    // Both request continuously for four single-beat cycles
`ifdef WB_ARB_ROUND_ROBIN_EN
    exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01; exp_seq[3] = 2'b10;
`else
    exp_seq[0] = 2'b10; exp_seq[1] = 2'b01; exp_seq[2] = 2'b10; exp_seq[3] = 2'b01;
`endif
    m0_req(32'h700, 1'b0, 32'h0);
    m1_req(32'h800, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      m0_bus.CYC = 1'b1; m0_bus.STB = 1'b1;
      m1_bus.CYC = 1'b1; m1_bus.STB = 1'b1;
      #1;
      check("rr_grant", grant, exp_seq[i]);
      s_bus.ACK = 1'b1; #1;
      check("rr_m0_ack", m0_bus.ACK, exp_seq[i][0]);
      check("rr_m1_ack", m1_bus.ACK, exp_seq[i][1]);
      @(negedge clk);
      s_bus.ACK = 1'b0;
      if (exp_seq[i] == 2'b01) begin
        m0_bus.CYC = 1'b0; m0_bus.STB = 1'b0;
      end else begin
        m1_bus.CYC = 1'b0; m1_bus.STB = 1'b0;
      end
    end
    m_idle();
    @(negedge clk);
    @(negedge clk); #1;
    check("rr_final_grant", grant, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
